// File: rtl/axis_tracker.sv
// axis_tracker: N-axis motor direction controller with dead-time brake and run timeout
module axis_tracker #(
  parameter int N_AXES     = 2,
  parameter int W          = 16,
  parameter int DEADBAND   = 4,
  parameter int DEAD_TIME  = 8,
  parameter int UPDATE_DIV = 1000,
  parameter int MAX_RUN    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sma,
  input  logic [N_AXES*W-1:0] sens_a,
  input  logic [N_AXES*W-1:0] sens_b,
  input  logic [N_AXES*W-1:0] pos_set,
  input  logic [N_AXES*W-1:0] pos_act,
  input  logic                fault_clr,
  output logic [N_AXES-1:0]   drv_pos,
  output logic [N_AXES-1:0]   drv_neg,
  output logic [N_AXES-1:0]   settled,
  output logic [N_AXES-1:0]   fault
);
  localparam int CW = $clog2(UPDATE_DIV);
  localparam int DW = $clog2(DEAD_TIME + 1);
  localparam int RW = $clog2(MAX_RUN + 2);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RUN_POS = 3'd1;
  localparam logic [2:0] RUN_NEG = 3'd2;
  localparam logic [2:0] BRAKE   = 3'd3;
  localparam logic [2:0] FAULT   = 3'd4;
  localparam logic signed [W:0] DB      = (W+1)'(DEADBAND);
  localparam logic [DW-1:0]     DT_LOAD = DW'(DEAD_TIME - 1);
  localparam logic [CW-1:0]     CNT_MAX = CW'(UPDATE_DIV - 1);
  localparam logic [RW-1:0]     RUN_LIM = RW'(MAX_RUN);

  logic [CW-1:0] cnt_q;
  logic          sma_q, sma_prev_q;
  logic          tick, chg;

  assign tick = cnt_q == CNT_MAX;
  assign chg  = sma_q ^ sma_prev_q;

  // shared tick divider and mode-sample history for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      sma_q      <= 1'b0;
      sma_prev_q <= 1'b0;
    end else begin
      cnt_q      <= tick ? '0 : cnt_q + 1'b1;
      sma_q      <= sma;
      sma_prev_q <= sma_q;
    end
  end

  for (genvar i = 0; i < N_AXES; i++) begin : g_ax
    logic [2:0]      st_q, st_d;
    logic [DW-1:0]   dt_q, dt_d;
    logic [RW-1:0]   run_q, run_d, run_inc;
    logic            set_q, set_d;
    logic [W-1:0]    a, b;
    logic signed [W:0] e;
    logic            dpos, dneg, running;

    assign a       = sma_q ? sens_a[i*W +: W] : pos_set[i*W +: W];
    assign b       = sma_q ? sens_b[i*W +: W] : pos_act[i*W +: W];
    assign e       = $signed({1'b0, a}) - $signed({1'b0, b});
    assign dpos    = e > DB;
    assign dneg    = e < -DB;
    assign running = st_q == RUN_POS || st_q == RUN_NEG;
    assign run_inc = run_q + 1'b1;

    // axis FSM: fault clear, mode-change brake, timeout, then tick-driven demand
    always_comb begin
      st_d  = st_q;
      dt_d  = dt_q;
      run_d = run_q;
      set_d = tick ? (st_q == IDLE && !dpos && !dneg) : set_q;
      if (st_q == FAULT) begin
        st_d = fault_clr ? IDLE : FAULT;
      end else if (st_q == BRAKE) begin
        dt_d = dt_q - 1'b1;
        st_d = dt_q == '0 ? IDLE : BRAKE;
      end else if (running && chg) begin
        st_d = BRAKE;
        dt_d = DT_LOAD;
      end else if (tick) begin
        if (running && MAX_RUN > 0 && run_inc == RUN_LIM) begin
          st_d = FAULT;
        end else if (st_q == IDLE) begin
          st_d  = dpos ? RUN_POS : dneg ? RUN_NEG : IDLE;
          run_d = '0;
        end else begin
          run_d = run_inc;
          if ((st_q == RUN_POS && !dpos) || (st_q == RUN_NEG && !dneg)) begin
            st_d = BRAKE;
            dt_d = DT_LOAD;
          end
        end
      end
    end

    // axis state registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= IDLE;
        dt_q  <= '0;
        run_q <= '0;
        set_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        dt_q  <= dt_d;
        run_q <= run_d;
        set_q <= set_d;
      end
    end

    assign drv_pos[i] = st_q == RUN_POS;
    assign drv_neg[i] = st_q == RUN_NEG;
    assign fault[i]   = st_q == FAULT;
    assign settled[i] = set_q;
  end
endmodule

// File: tb/tb_axis_tracker.sv
// tb_axis_tracker: directed cycle-accurate checks of the axis_tracker controller
module tb_axis_tracker;
  logic        clk, rst, sma, fault_clr;
  logic [31:0] sens_a, sens_b, pos_set, pos_act;
  logic [1:0]  drv_pos, drv_neg, settled, fault;
  int          n_vec = 0;
  int          n_err = 0;
  int          cur = 0;

  axis_tracker #(
    .N_AXES(2), .W(16), .DEADBAND(4), .DEAD_TIME(8), .UPDATE_DIV(4), .MAX_RUN(16)
  ) dut (
    .clk(clk), .rst(rst), .sma(sma),
    .sens_a(sens_a), .sens_b(sens_b), .pos_set(pos_set), .pos_act(pos_act),
    .fault_clr(fault_clr),
    .drv_pos(drv_pos), .drv_neg(drv_neg), .settled(settled), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // opposing drives must never be enabled together
  always @(negedge clk) begin
    assert ((drv_pos & drv_neg) === 2'b00)
    else begin
      n_err++;
      $error("FAIL overlap observed=%b/%b expected=no common bit", drv_pos, drv_neg);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int c);
    while (cur < c) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  initial begin
    rst = 1'b1; sma = 1'b0; fault_clr = 1'b0;
    sens_a = '0; sens_b = '0;
    pos_set = {16'd0, 16'd100};
    pos_act = {16'd0, 16'd90};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_drv_pos", {30'd0, drv_pos}, 0);
    chk("rst_drv_neg", {30'd0, drv_neg}, 0);
    chk("rst_settled", {30'd0, settled}, 0);
    chk("rst_fault", {30'd0, fault}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; cur = 0;
    go(3);  chk("t1_c3_pos", {30'd0, drv_pos}, 2'b00);
    go(4);  chk("t1_c4_pos", {30'd0, drv_pos}, 2'b01);
            chk("t1_c4_neg", {30'd0, drv_neg}, 2'b00);
            chk("t1_c4_settled", {30'd0, settled}, 2'b10);
    pos_act[15:0] = 16'd120;
    pos_set[31:16] = 16'd104; pos_act[31:16] = 16'd100;
    go(7);  chk("t3_c7_pos", {30'd0, drv_pos}, 2'b01);
    go(8);  chk("t3_brake_pos", {30'd0, drv_pos}, 2'b00);
            chk("t3_brake_neg", {30'd0, drv_neg}, 2'b00);
            chk("t2_p4_settled", {30'd0, settled}, 2'b10);
    pos_set[31:16] = 16'd96;
    go(12); chk("t2_m4_settled", {30'd0, settled}, 2'b10);
            chk("t2_m4_pos", {30'd0, drv_pos}, 2'b00);
            chk("t2_m4_neg", {30'd0, drv_neg}, 2'b00);
    pos_set[31:16] = 16'd105;
    go(15); chk("t3_c15_pos", {30'd0, drv_pos}, 2'b00);
            chk("t3_c15_neg", {30'd0, drv_neg}, 2'b00);
    go(16); chk("t2_p5_pos", {30'd0, drv_pos}, 2'b10);
            chk("t2_p5_settled", {30'd0, settled}, 2'b00);
    pos_set[31:16] = 16'd95;
    go(19); chk("t3_c19_neg", {30'd0, drv_neg}, 2'b00);
    go(20); chk("t3_c20_neg", {30'd0, drv_neg}, 2'b01);
            chk("t3_c20_pos", {30'd0, drv_pos}, 2'b00);
    go(32); chk("t2_m5_neg", {30'd0, drv_neg}, 2'b11);
    sma = 1'b1; sens_a[31:16] = 16'd500; sens_b[31:16] = 16'd100;
    go(33); chk("t4_k1_neg", {30'd0, drv_neg}, 2'b11);
    go(34); chk("t4_k2_neg", {30'd0, drv_neg}, 2'b00);
            chk("t4_k2_pos", {30'd0, drv_pos}, 2'b00);
    go(44); chk("t4_auto_pos", {30'd0, drv_pos}, 2'b10);
            chk("t4_auto_settled", {30'd0, settled}, 2'b01);
    go(45);
    sma = 1'b0;
    pos_set = {16'd0, 16'd100}; pos_act = {16'd0, 16'd100};
    go(46); chk("t4_tog_k1", {30'd0, drv_pos}, 2'b10);
    go(47); chk("t4_tog_k2", {30'd0, drv_pos}, 2'b00);
    go(48);
    pos_set[15:0] = 16'd200;
    go(52);  chk("t5_run", {30'd0, drv_pos}, 2'b01);
    go(115); chk("t5_pre_pos", {30'd0, drv_pos}, 2'b01);
             chk("t5_pre_fault", {30'd0, fault}, 2'b00);
    go(116); chk("t5_fault", {30'd0, fault}, 2'b01);
             chk("t5_fault_pos", {30'd0, drv_pos}, 2'b00);
    go(117);
    fault_clr = 1'b1;
             chk("t5_clr_same", {30'd0, fault}, 2'b01);
    go(118);
    fault_clr = 1'b0;
             chk("t5_clr_fault", {30'd0, fault}, 2'b00);
             chk("t5_clr_pos", {30'd0, drv_pos}, 2'b00);
    go(119); chk("t5_c119_pos", {30'd0, drv_pos}, 2'b00);
    go(120); chk("t5_rerun", {30'd0, drv_pos}, 2'b01);
    pos_set[31:16] = 16'd50;
    go(124); chk("t6_both", {30'd0, drv_pos}, 2'b11);
    rst = 1'b1;
    #1;
    chk("t6_async_pos", {30'd0, drv_pos}, 2'b00);
    chk("t6_async_neg", {30'd0, drv_neg}, 2'b00);
    chk("t6_async_settled", {30'd0, settled}, 2'b00);
    chk("t6_async_fault", {30'd0, fault}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; cur = 0;
    go(3); chk("t6_c3_pos", {30'd0, drv_pos}, 2'b00);
    go(4); chk("t6_c4_pos", {30'd0, drv_pos}, 2'b11);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
